spi_pixel_loader: RTL and testbench

- Sits directly downstream of spi_slave and consumes its byte stream: read_value, the done strobe and first_byte.
- Parses a per-transaction command protocol and turns GRB byte triples into 24-bit pixel writes into the WS2812B frame buffer.
- Issues a held refresh request to the WS2812B output driver.

---
 rtl/spi_pixel_loader_if.sv | 32 +++
 rtl/spi_pixel_loader.sv | 153 +++++++++++++++
 tb/tb_spi_pixel_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pixel_loader_if.sv
// spi_pixel_loader_if
// Groups the byte stream coming from spi_slave, the frame buffer write port
// and the refresh handshake with the WS2812B driver.
//   byte_in/byte_valid/first_byte : received byte, its strobe, first-after-CS flag
//   wr_en/wr_addr/wr_data         : one-cycle pixel write, data packed {G,R,B}
//   show_req/show_ack             : held refresh request and its acknowledge
//   cmd_error                     : one-cycle pulse on a rejected command/address
// The slave modport is the loader's view; the master modport is the
// surrounding environment's view.
interface spi_pixel_loader_if #(
  parameter int ADDR_WIDTH = 6
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  first_byte;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [23:0]           wr_data;
  logic                  show_req;
  logic                  show_ack;
  logic                  cmd_error;

  modport slave (
    input  byte_in, byte_valid, first_byte, show_ack,
    output wr_en, wr_addr, wr_data, show_req, cmd_error
  );

  modport master (
    output byte_in, byte_valid, first_byte, show_ack,
    input  wr_en, wr_addr, wr_data, show_req, cmd_error
  );
endinterface

// File: rtl/spi_pixel_loader.sv
// spi_pixel_loader
// Parses the per-transaction command stream from spi_slave and turns GRB
// byte triples into 24-bit frame buffer writes; raises a held refresh request
// for the WS2812B driver.
// Ports:
//   clk     : system clock
//   resetn  : synchronous active-low reset
//   bus     : spi_pixel_loader_if.slave (byte input, pixel write, show handshake,
//             cmd_error)
// Packet formats (first byte flagged by first_byte):
//   CMD_WRITE, addr_hi, addr_lo, {G, R, B}*  -> consecutive pixel writes
//   CMD_SHOW                                 -> refresh request
// ADDR_WIDTH is assumed to be at most 16 (start address is 16 bits on the wire).
module spi_pixel_loader #(
  parameter int         NUM_PIXELS = 64,
  parameter int         ADDR_WIDTH = 6,
  parameter logic [7:0] CMD_WRITE  = 8'h81,
  parameter logic [7:0] CMD_SHOW   = 8'h82
) (
  input  logic                clk,
  input  logic                resetn,
  spi_pixel_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_H  = 3'd1,
    ADDR_L  = 3'd2,
    PIX     = 3'd3,
    DISCARD = 3'd4
  } state_t;

  localparam logic [16:0]           NUM_PIX_W = 17'(NUM_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(NUM_PIXELS - 1);

  state_t                state_q, state_d;
  logic [7:0]            addr_h_q, addr_h_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [1:0]            idx_q, idx_d;
  logic [7:0]            g_q, g_d;
  logic [7:0]            r_q, r_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]           wr_data_q, wr_data_d;
  logic                  show_req_q, show_req_d;
  logic                  cmd_error_q, cmd_error_d;
  logic [15:0]           addr16;

  assign addr16 = {addr_h_q, bus.byte_in};

  always_comb begin
    state_d     = state_q;
    addr_h_d    = addr_h_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    g_d         = g_q;
    r_d         = r_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cmd_error_d = 1'b0;
    // An acknowledge clears the request unless a new CMD_SHOW sets it below.
    show_req_d  = show_req_q & ~bus.show_ack;

    if (bus.byte_valid) begin
      if (bus.first_byte) begin
        // A command byte always restarts parsing; any partial triple is dropped.
        idx_d = 2'd0;
        if (bus.byte_in == CMD_WRITE) begin
          state_d = ADDR_H;
        end else if (bus.byte_in == CMD_SHOW) begin
          show_req_d = 1'b1;
          state_d    = DISCARD;
        end else begin
          cmd_error_d = 1'b1;
          state_d     = DISCARD;
        end
      end else begin
        unique case (state_q)
          ADDR_H: begin
            addr_h_d = bus.byte_in;
            state_d  = ADDR_L;
          end
          ADDR_L: begin
            if ({1'b0, addr16} < NUM_PIX_W) begin
              ptr_d   = addr16[ADDR_WIDTH-1:0];
              idx_d   = 2'd0;
              state_d = PIX;
            end else begin
              cmd_error_d = 1'b1;
              state_d     = DISCARD;
            end
          end
          PIX: begin
            unique case (idx_q)
              2'd0: begin
                g_d   = bus.byte_in;
                idx_d = 2'd1;
              end
              2'd1: begin
                r_d   = bus.byte_in;
                idx_d = 2'd2;
              end
              default: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = {g_q, r_q, bus.byte_in};
                ptr_d     = (ptr_q == LAST_PTR) ? '0 : ptr_q + 1'b1;
                idx_d     = 2'd0;
              end
            endcase
          end
          default: ;  // IDLE and DISCARD ignore data bytes
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      addr_h_q    <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      g_q         <= '0;
      r_q         <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      show_req_q  <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_h_q    <= addr_h_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      g_q         <= g_d;
      r_q         <= r_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      show_req_q  <= show_req_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.show_req  = show_req_q;
  assign bus.cmd_error = cmd_error_q;

endmodule

// File: tb/tb_spi_pixel_loader.sv
// tb_spi_pixel_loader
// Drives byte streams into spi_pixel_loader and compares every output, every
// cycle, with a packet-level reference model: the model keeps the bytes of the
// current transaction and derives writes/errors from the packet contents.
module tb_spi_pixel_loader;
  localparam int NUM_PIXELS = 64;
  localparam int ADDR_WIDTH = 6;

  logic clk;
  logic resetn;

  spi_pixel_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  spi_pixel_loader #(
    .NUM_PIXELS(NUM_PIXELS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CMD_WRITE (8'h81),
    .CMD_SHOW  (8'h82)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit [7:0] pkt[$];
  int       exp_addr = 0;
  int       exp_data = 0;
  bit       exp_show = 0;
  int       n_writes = 0;
  int       n_cmderr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, update the model, sample 1 time unit after posedge.
  task automatic tick(input bit bv, input bit fb, input logic [7:0] b, input bit ack);
    bit exp_wr;
    bit exp_err;
    int n;
    int a;
    @(negedge clk);
    bus.byte_valid = bv;
    bus.first_byte = fb;
    bus.byte_in    = b;
    bus.show_ack   = ack;
    exp_wr  = 0;
    exp_err = 0;
    if (bv && fb && b == 8'h82) exp_show = 1;
    else if (ack)               exp_show = 0;
    if (bv) begin
      if (fb) begin
        pkt.delete();
        pkt.push_back(b);
        if (b != 8'h81 && b != 8'h82) exp_err = 1;
      end else if (pkt.size() > 0) begin
        pkt.push_back(b);
        n = pkt.size();
        if (pkt[0] == 8'h81 && n >= 3) begin
          a = {16'd0, pkt[1], pkt[2]};
          if (n == 3 && a >= NUM_PIXELS) exp_err = 1;
          if (a < NUM_PIXELS && n > 3 && (n - 3) % 3 == 0) begin
            exp_wr   = 1;
            exp_addr = (a + (n - 3) / 3 - 1) % NUM_PIXELS;
            exp_data = {8'd0, pkt[n-3], pkt[n-2], pkt[n-1]};
          end
        end
      end
    end
    if (exp_wr)  n_writes++;
    if (exp_err) n_cmderr++;
    @(posedge clk);
    #1;
    chk("wr_en",     {31'd0, bus.wr_en},     {31'd0, exp_wr});
    chk("wr_addr",   {26'd0, bus.wr_addr},   exp_addr);
    chk("wr_data",   {8'd0, bus.wr_data},    exp_data);
    chk("cmd_error", {31'd0, bus.cmd_error}, {31'd0, exp_err});
    chk("show_req",  {31'd0, bus.show_req},  {31'd0, exp_show});
  endtask

  task automatic tx(input logic [7:0] b, input bit fb);
    tick(1'b1, fb, b, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn         = 1'b0;
    bus.byte_valid = 1'b0;
    bus.first_byte = 1'b0;
    bus.show_ack   = 1'b0;
    pkt.delete();
    exp_addr = 0;
    exp_data = 0;
    exp_show = 0;
    @(posedge clk);
    #1;
    chk("rst_wr_en",     {31'd0, bus.wr_en},     32'd0);
    chk("rst_wr_addr",   {26'd0, bus.wr_addr},   32'd0);
    chk("rst_wr_data",   {8'd0, bus.wr_data},    32'd0);
    chk("rst_cmd_error", {31'd0, bus.cmd_error}, 32'd0);
    chk("rst_show_req",  {31'd0, bus.show_req},  32'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int w0;
    int e0;
    logic [7:0] b;
    bit ack;
    resetn         = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.first_byte = 1'b0;
    bus.show_ack   = 1'b0;
    do_reset();

    // Data byte in IDLE is ignored
    tx(8'h55, 1'b0);

    // Two consecutive pixels from address 5
    w0 = n_writes;
    tx(8'h81, 1); tx(8'h00, 0); tx(8'h05, 0);
    tx(8'h10, 0); tx(8'h20, 0); tx(8'h30, 0);
    chk("pix5_addr", {26'd0, bus.wr_addr}, 32'd5);
    chk("pix5_data", {8'd0, bus.wr_data},  32'h102030);
    tx(8'h40, 0); tx(8'h50, 0); tx(8'h60, 0);
    chk("pix6_addr", {26'd0, bus.wr_addr}, 32'd6);
    chk("pix6_data", {8'd0, bus.wr_data},  32'h405060);
    tick(0, 0, 8'h00, 0);
    chk("pix_hold", {8'd0, bus.wr_data}, 32'h405060);
    chk("pix5_cnt", n_writes - w0, 32'd2);

    // Wrap from the last pixel to 0
    tx(8'h81, 1); tx(8'h00, 0); tx(8'h3F, 0);
    tx(8'h11, 0); tx(8'h22, 0); tx(8'h33, 0);
    chk("wrap_a63", {26'd0, bus.wr_addr}, 32'd63);
    tx(8'h44, 0); tx(8'h55, 0); tx(8'h66, 0);
    chk("wrap_a0", {26'd0, bus.wr_addr}, 32'd0);
    chk("wrap_d0", {8'd0, bus.wr_data}, 32'h445566);

    // Out-of-range start address, then a valid packet at 0
    e0 = n_cmderr; w0 = n_writes;
    tx(8'h81, 1); tx(8'h00, 0); tx(8'h40, 0);
    tx(8'h01, 0); tx(8'h02, 0); tx(8'h03, 0);
    tx(8'h81, 1); tx(8'h00, 0); tx(8'h00, 0);
    tx(8'hA1, 0); tx(8'hB2, 0); tx(8'hC3, 0);
    chk("oor_err_cnt", n_cmderr - e0, 32'd1);
    chk("oor_wr_cnt",  n_writes - w0, 32'd1);
    chk("oor_addr", {26'd0, bus.wr_addr}, 32'd0);

    // Incomplete triple flushed by the next command
    w0 = n_writes;
    tx(8'h81, 1); tx(8'h00, 0); tx(8'h02, 0); tx(8'hAA, 0); tx(8'hBB, 0);
    tx(8'h81, 1); tx(8'h00, 0); tx(8'h03, 0);
    tx(8'h07, 0); tx(8'h08, 0); tx(8'h09, 0);
    chk("flush_cnt",  n_writes - w0, 32'd1);
    chk("flush_addr", {26'd0, bus.wr_addr}, 32'd3);
    chk("flush_data", {8'd0, bus.wr_data}, 32'h070809);

    // Show request: held, coalesced, cleared by ack; set wins over ack
    tx(8'h82, 1);
    tick(0, 0, 8'h00, 0);
    tx(8'h82, 1);
    chk("show_held", {31'd0, bus.show_req}, 32'd1);
    tick(0, 0, 8'h00, 1);
    chk("show_clr", {31'd0, bus.show_req}, 32'd0);
    tick(1, 1, 8'h82, 1);
    chk("show_setwins", {31'd0, bus.show_req}, 32'd1);
    tick(0, 0, 8'h00, 1);

    // Unknown command, then ignored bytes
    tx(8'h7F, 1);
    tx(8'h00, 0); tx(8'h00, 0); tx(8'h00, 0); tx(8'h12, 0); tx(8'h34, 0);

    // Reset mid-packet: the partial pixel must not complete afterwards
    tx(8'h81, 1); tx(8'h00, 0); tx(8'h09, 0); tx(8'hDE, 0); tx(8'hAD, 0);
    do_reset();
    tx(8'hBE, 0); tx(8'h01, 0); tx(8'h02, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r   = $urandom_range(0, 99);
      ack = ($urandom_range(0, 3) == 0);
      if (r < 2) begin
        do_reset();
      end else if (r < 12 || pkt.size() == 0) begin
        int c;
        c = $urandom_range(0, 9);
        b = (c < 6) ? 8'h81 : (c < 8) ? 8'h82 : 8'($urandom);
        tick(1, 1, b, ack);
      end else begin
        if (pkt[0] == 8'h81 && pkt.size() == 1)
          b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        else if (pkt[0] == 8'h81 && pkt.size() == 2)
          b = 8'($urandom_range(0, 70));
        else
          b = 8'($urandom);
        tick(1, 0, b, ack);
      end
      repeat ($urandom_range(0, 2))
        tick(0, 1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
